// File: rtl/rv32i_types_pkg.sv
// Shared vector types: mask-op enum, mask sequencer state encoding and constants.
package rv32i_types_pkg;

  typedef enum logic [2:0] {
    VMASK_AND   = 3'd0,
    VMASK_OR    = 3'd1,
    VMASK_XOR   = 3'd2,
    VMASK_NAND  = 3'd3,
    VMASK_POPC  = 3'd4,
    VMASK_FIRST = 3'd5,
    VMASK_IOTA  = 3'd6,
    VMASK_ID    = 3'd7
  } vmask_op_t;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'd0,
    MS_FETCH = 2'd1,
    MS_ELEM  = 2'd2,
    MS_DONE  = 2'd3
  } mask_seq_state_t;

  localparam logic [31:0] VMASK_NONE_FOUND = 32'hFFFF_FFFF;

  // Ops that need the multi-word sequencer.
  function automatic logic vmask_seq_op(input vmask_op_t op);
    return (op == VMASK_POPC) || (op == VMASK_FIRST) ||
           (op == VMASK_IOTA) || (op == VMASK_ID);
  endfunction

endpackage

// File: rtl/mask_word_scan.sv
// Combinational scan of one 32-bit mask word: popcount, lowest set bit, any set.
module mask_word_scan (
  input  logic [31:0] eff,
  output logic [5:0]  popcount,
  output logic [4:0]  lowest_set,
  output logic        any
);

  always_comb begin
    popcount   = '0;
    lowest_set = '0;
    any        = |eff;
    for (int i = 0; i < 32; i++) begin
      popcount = popcount + 6'(eff[i]);
    end
    // Descending walk so the lowest set bit is the last one written.
    for (int i = 31; i >= 0; i--) begin
      if (eff[i]) lowest_set = 5'(i);
    end
  end

endmodule

// File: rtl/mask_seq_ctrl.sv
// Multi-word sequencer for vcpop/vfirst/viota/vid in the vector mask unit.
// Build option: MASK_SEQ_FIRST_EARLY_EXIT_EN stops FIRST at the first word with a hit.
module mask_seq_ctrl
  import rv32i_types_pkg::*;
#(
  parameter int unsigned MAX_VL = 512,
  parameter int unsigned VLW    = $clog2(MAX_VL) + 1,
  parameter int unsigned WIW    = $clog2(MAX_VL / 32)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            start,
  input  vmask_op_t       op,
  input  logic [VLW-1:0]  vl,
  input  logic            vm,
  input  logic            flush,
  output logic            busy,
  output logic            word_req,
  output logic [WIW-1:0]  word_idx,
  input  logic            word_valid,
  input  logic [31:0]     vs2_word,
  input  logic [31:0]     v0_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLW-1:0]  out_idx,
  output logic [31:0]     offset,
  output logic [31:0]     iota_res,
  output logic            out_we,
  output logic            done,
  output logic [31:0]     scalar_result
);

  mask_seq_state_t state;
  vmask_op_t       op_q;
  logic            vm_q;
  logic [VLW-1:0]  vl_q;
  logic [VLW-1:0]  count;
  logic [VLW-1:0]  result;
  logic            found;
  logic [31:0]     vs2_q;
  logic [31:0]     v0_q;

  logic [VLW-1:0]  base;
  logic [VLW-1:0]  rem;
  logic [31:0]     tail;
  logic [31:0]     eff;
  logic [5:0]      scan_pop;
  logic [4:0]      scan_low;
  logic            scan_any;
  logic            last_word;
  logic            first_hit;
  logic            found_n;
  logic [VLW-1:0]  result_n;
  logic [VLW-1:0]  count_pop;
  logic [31:0]     first_scalar;
  logic            scan_stop;
  logic [4:0]      b;
  logic            elem_bit;
  logic [VLW-1:0]  idx_n;

  // Word-level datapath: tail-masked, v0-gated word and its scan.
  assign base      = VLW'({word_idx, 5'b0});
  assign rem       = vl_q - base;
  assign tail      = (rem >= VLW'(32)) ? 32'hFFFF_FFFF : ((32'd1 << rem) - 32'd1);
  assign eff       = vs2_word & (vm_q ? 32'hFFFF_FFFF : v0_word) & tail;
  assign last_word = (word_idx == WIW'((vl_q - VLW'(1)) >> 5));

  mask_word_scan u_scan (
    .eff        (eff),
    .popcount   (scan_pop),
    .lowest_set (scan_low),
    .any        (scan_any)
  );

  assign first_hit    = (op_q == VMASK_FIRST) && !found && scan_any;
  assign found_n      = found | first_hit;
  assign result_n     = first_hit ? (base + VLW'(scan_low)) : result;
  assign count_pop    = count + VLW'(scan_pop);
  assign first_scalar = found_n ? 32'(result_n) : VMASK_NONE_FOUND;

`ifdef MASK_SEQ_FIRST_EARLY_EXIT_EN
  assign scan_stop = last_word || ((op_q == VMASK_FIRST) && found_n);
`else
  assign scan_stop = last_word;
`endif

  // Element-level datapath for IOTA/ID streaming.
  assign b        = out_idx[4:0];
  assign elem_bit = vs2_q[b] & (vm_q | v0_q[b]);
  assign idx_n    = out_idx + VLW'(1);

  // Handshake outputs decode straight from the state register.
  assign busy      = (state != MS_IDLE);
  assign word_req  = (state == MS_FETCH);
  assign out_valid = (state == MS_ELEM);
  assign done      = (state == MS_DONE);
  assign offset    = 32'(out_idx);
  assign iota_res  = 32'(count);
  assign out_we    = (state == MS_ELEM) & (vm_q | v0_q[b]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= MS_IDLE;
      op_q          <= VMASK_POPC;
      vm_q          <= 1'b0;
      vl_q          <= '0;
      word_idx      <= '0;
      out_idx       <= '0;
      count         <= '0;
      result        <= '0;
      found         <= 1'b0;
      vs2_q         <= '0;
      v0_q          <= '0;
      scalar_result <= '0;
    end else if (flush) begin
      state <= MS_IDLE;
    end else begin
      case (state)
        MS_IDLE: begin
          if (start) begin
            op_q     <= op;
            vm_q     <= vm;
            vl_q     <= vl;
            word_idx <= '0;
            out_idx  <= '0;
            count    <= '0;
            result   <= '0;
            found    <= 1'b0;
            if ((vl == '0) || !vmask_seq_op(op)) begin
              state         <= MS_DONE;
              scalar_result <= (op == VMASK_POPC) ? 32'd0 : VMASK_NONE_FOUND;
            end else begin
              state <= MS_FETCH;
            end
          end
        end
        MS_FETCH: begin
          if (word_valid) begin
            vs2_q <= vs2_word;
            v0_q  <= v0_word;
            if ((op_q == VMASK_POPC) || (op_q == VMASK_FIRST)) begin
              if (op_q == VMASK_POPC) count <= count_pop;
              found  <= found_n;
              result <= result_n;
              if (scan_stop) begin
                state         <= MS_DONE;
                scalar_result <= (op_q == VMASK_POPC) ? 32'(count_pop) : first_scalar;
              end else begin
                word_idx <= word_idx + WIW'(1);
              end
            end else begin
              state <= MS_ELEM;
            end
          end
        end
        MS_ELEM: begin
          if (out_ready) begin
            count   <= count + VLW'(elem_bit);
            out_idx <= idx_n;
            if (idx_n == vl_q) begin
              state         <= MS_DONE;
              scalar_result <= 32'd0;
            end else if (b == 5'd31) begin
              state    <= MS_FETCH;
              word_idx <= word_idx + WIW'(1);
            end
          end
        end
        MS_DONE: state <= MS_IDLE;
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_seq_ctrl.sv
// Self-checking bench for mask_seq_ctrl against an element-level reference model.
module tb_mask_seq_ctrl;
  import rv32i_types_pkg::*;

  localparam int unsigned MAX_VL = 512;
  localparam int unsigned VLW    = 10;
  localparam int unsigned WIW    = 4;
  localparam int unsigned NW     = MAX_VL / 32;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            start;
  vmask_op_t       op;
  logic [VLW-1:0]  vl;
  logic            vm;
  logic            flush;
  logic            busy;
  logic            word_req;
  logic [WIW-1:0]  word_idx;
  logic            word_valid;
  logic [31:0]     vs2_word;
  logic [31:0]     v0_word;
  logic            out_valid;
  logic            out_ready;
  logic [VLW-1:0]  out_idx;
  logic [31:0]     offset;
  logic [31:0]     iota_res;
  logic            out_we;
  logic            done;
  logic [31:0]     scalar_result;

  logic [31:0] vs2_mem [NW];
  logic [31:0] v0_mem  [NW];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_scalar = 32'd0;

  always #5 CLK = ~CLK;

  assign vs2_word = vs2_mem[word_idx];
  assign v0_word  = v0_mem[word_idx];

  mask_seq_ctrl #(.MAX_VL(MAX_VL), .VLW(VLW), .WIW(WIW)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .vl(vl), .vm(vm), .flush(flush),
    .busy(busy), .word_req(word_req), .word_idx(word_idx), .word_valid(word_valid),
    .vs2_word(vs2_word), .v0_word(v0_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .offset(offset), .iota_res(iota_res), .out_we(out_we),
    .done(done), .scalar_result(scalar_result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit vs2bit(input int i);
    return vs2_mem[WIW'(i / 32)][5'(i % 32)];
  endfunction

  function automatic bit v0bit(input int i);
    return v0_mem[WIW'(i / 32)][5'(i % 32)];
  endfunction

  // rdy_mode: 0 always ready, 1 toggle, 2 random. vld_mode: 0 always valid, 1 random.
  task automatic run_op(input vmask_op_t o, input int vl_i, input bit vm_i,
                        input int rdy_mode, input int vld_mode, input int flush_at);
    int          exp_idx[$];
    int          exp_iota[$];
    bit          exp_we[$];
    int          nw, cnt, first, exp_req, exp_lat, cyc, n_req, n_pop, done_cyc;
    logic [31:0] exp_scalar;
    bit          supported, is_elem, finished, tog, a, g;

    nw        = (vl_i + 31) / 32;
    supported = (o == VMASK_POPC) || (o == VMASK_FIRST) || (o == VMASK_IOTA) || (o == VMASK_ID);
    cnt       = 0;
    first     = -1;
    for (int i = 0; i < vl_i; i++) begin
      g = vm_i | v0bit(i);
      a = vs2bit(i) & g;
      exp_idx.push_back(i);
      exp_iota.push_back(cnt);
      exp_we.push_back(g);
      if (a && first < 0) first = i;
      cnt += int'(a);
    end
    is_elem = supported && (o == VMASK_IOTA || o == VMASK_ID) && vl_i > 0;
    if (!supported || vl_i == 0) begin
      exp_scalar = (o == VMASK_POPC) ? 32'd0 : 32'hFFFF_FFFF;
      exp_req    = 0;
      exp_lat    = 1;
    end else if (o == VMASK_POPC) begin
      exp_scalar = 32'(cnt);
      exp_req    = nw;
      exp_lat    = nw + 1;
    end else if (o == VMASK_FIRST) begin
      exp_scalar = (first < 0) ? 32'hFFFF_FFFF : 32'(first);
`ifdef MASK_SEQ_FIRST_EARLY_EXIT_EN
      exp_req    = (first < 0) ? nw : first / 32 + 1;
`else
      exp_req    = nw;
`endif
      exp_lat    = exp_req + 1;
    end else begin
      exp_scalar = 32'd0;
      exp_req    = nw;
      exp_lat    = nw + vl_i + 1;
    end

    @(negedge CLK);
    op = o; vl = VLW'(vl_i); vm = vm_i; start = 1'b1;
    out_ready = 1'b0; word_valid = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    op = vmask_op_t'(3'($urandom)); vl = VLW'($urandom); vm = 1'($urandom);

    cyc = 0; n_req = 0; n_pop = 0; finished = 0; tog = 0; done_cyc = -1;
    while (!finished && cyc < 4000) begin
      cyc++;
      if (done) begin
        finished = 1;
        done_cyc = cyc;
        chk("scalar_result", scalar_result, exp_scalar);
      end
      if (out_valid) begin
        if (n_pop < exp_idx.size()) begin
          chk("out_idx", 32'(out_idx), 32'(exp_idx[n_pop]));
          chk("offset", offset, 32'(exp_idx[n_pop]));
          if (o == VMASK_IOTA) chk("iota_res", iota_res, 32'(exp_iota[n_pop]));
          chk("out_we", 32'(out_we), 32'(exp_we[n_pop]));
        end else begin
          chk("elem_overrun", 32'(n_pop + 1), 32'(exp_idx.size()));
        end
      end
      if (flush_at >= 0 && out_valid && n_pop == flush_at) begin
        flush = 1'b1; out_ready = 1'b1; word_valid = 1'b1;
        @(negedge CLK);
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_word_req", 32'(word_req), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        repeat (4) begin
          @(negedge CLK);
          chk("flush_no_done", 32'(done), 32'd0);
        end
        chk("flush_scalar_hold", scalar_result, last_scalar);
        return;
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       begin tog = ~tog; out_ready = tog; end
        default: out_ready = 1'($urandom);
      endcase
      word_valid = (vld_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) n_pop++;
      if (word_req && word_valid) begin
        chk("word_idx", 32'(word_idx), 32'(n_req));
        n_req++;
      end
      @(negedge CLK);
    end

    if (!finished) chk("done_timeout", 32'd0, 32'd1);
    chk("n_elem", 32'(n_pop), is_elem ? 32'(vl_i) : 32'd0);
    chk("n_word_req", 32'(n_req), 32'(exp_req));
    if (rdy_mode == 0 && vld_mode == 0) chk("latency", 32'(done_cyc), 32'(exp_lat));
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
    chk("scalar_hold", scalar_result, exp_scalar);
    last_scalar = exp_scalar;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_word_req"}, 32'(word_req), 32'd0);
    chk({pfx, "_word_idx"}, 32'(word_idx), 32'd0);
    chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({pfx, "_out_idx"}, 32'(out_idx), 32'd0);
    chk({pfx, "_offset"}, offset, 32'd0);
    chk({pfx, "_iota_res"}, iota_res, 32'd0);
    chk({pfx, "_out_we"}, 32'(out_we), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_scalar"}, scalar_result, 32'd0);
  endtask

  task automatic fill_words(input int sparse);
    for (int w = 0; w < NW; w++) begin
      vs2_mem[w] = ($urandom_range(0, 3) < sparse) ? 32'd0 : ($urandom & $urandom);
      v0_mem[w]  = $urandom;
    end
  endtask

  initial begin
    int vli;
    int osel;
    nRST = 1'b0; start = 1'b0; op = VMASK_POPC; vl = '0; vm = 1'b1;
    flush = 1'b0; word_valid = 1'b0; out_ready = 1'b0;
    for (int w = 0; w < NW; w++) begin vs2_mem[w] = 32'd0; v0_mem[w] = 32'd0; end
    repeat (2) @(negedge CLK);
    check_reset_values("reset");
    nRST = 1'b1;

    // POPC across a word with a dirty tail
    fill_words(0);
    vs2_mem[0] = 32'hFFFF_FFFF; vs2_mem[1] = 32'h0000_FFFF;
    run_op(VMASK_POPC, 40, 1'b1, 0, 0, -1);

    // Flush in the middle of the second word's elements
    fill_words(0);
    run_op(VMASK_IOTA, 50, 1'b1, 0, 0, 37);

    // FIRST, masked by v0
    fill_words(0);
    vs2_mem[0] = 32'h0; vs2_mem[1] = 32'h10;
    v0_mem[0]  = 32'h0; v0_mem[1]  = 32'hFFFF_FFFF;
    run_op(VMASK_FIRST, 64, 1'b0, 0, 0, -1);

    // FIRST, no hit
    vs2_mem[0] = 32'h0; vs2_mem[1] = 32'h0;
    run_op(VMASK_FIRST, 64, 1'b1, 0, 0, -1);

    // IOTA with toggling backpressure
    fill_words(0);
    vs2_mem[0] = 32'b10110;
    run_op(VMASK_IOTA, 5, 1'b1, 1, 0, -1);

    // ID across a word boundary, masked
    fill_words(0);
    v0_mem[0] = 32'h1; v0_mem[1] = 32'h2;
    run_op(VMASK_ID, 34, 1'b0, 0, 0, -1);

    // Degenerate requests
    run_op(VMASK_POPC, 0, 1'b1, 0, 0, -1);
    run_op(VMASK_XOR, 10, 1'b1, 0, 0, -1);
    run_op(VMASK_FIRST, 0, 1'b1, 0, 0, -1);

    // Async reset in the middle of FETCH
    fill_words(0);
    vs2_mem[0] = 32'hFFFF_FFFF;
    run_op(VMASK_POPC, 32, 1'b1, 0, 0, -1);
    @(negedge CLK);
    op = VMASK_POPC; vl = VLW'(200); vm = 1'b1; start = 1'b1; word_valid = 1'b0;
    @(negedge CLK);
    start = 1'b0; word_valid = 1'b1;
    @(negedge CLK);
    word_valid = 1'b0;
    chk("pre_rst_word_req", 32'(word_req), 32'd1);
    chk("pre_rst_word_idx", 32'(word_idx), 32'd1);
    #2 nRST = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge CLK);
    nRST = 1'b1;
    last_scalar = 32'd0;

    // Random operations
    for (int t = 0; t < 30; t++) begin
      fill_words((t % 2 == 1) ? 3 : 1);
      osel = $urandom_range(0, 7);
      vli  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, MAX_VL) : $urandom_range(0, 96);
      run_op(vmask_op_t'(3'(osel)), vli, 1'($urandom), $urandom_range(0, 2),
             $urandom_range(0, 1), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
